ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 byte transmitter (e.g. LED/typematic commands to the keyboard).
//  - Runs the full PS/2 host request: inhibit, request-to-send, 8 data bits, odd parity,

---
 rtl/ps2_host_tx_if.sv | 23 ++
 rtl/ps2_host_tx.sv | 162 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Host-side PS/2 transmit bundle: byte handshake, status pulses and the open-drain line pair.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_low;
    logic       ps2_data_low;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data, tx_valid, ps2_clk_i, ps2_data_i,
        input  tx_ready, ps2_clk_low, ps2_data_low, tx_busy, tx_done, tx_error
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_i, ps2_data_i,
        output tx_ready, ps2_clk_low, ps2_data_low, tx_busy, tx_done, tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 8 data + odd parity + stop, ACK.
// Optional bus timeout in SEND/ACK/WAIT_IDLE is enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic           clk,
    input  logic           resetn,
    ps2_host_tx_if.slave   bus
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_clk_prev;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic [3:0]       r_bit_cnt;
    logic [INH_W-1:0] r_inh_cnt;
    logic             r_data_low;
    logic             w_fall;
    logic             w_accept;
    logic             w_inh_last;
    logic             w_timeout;
    logic             w_done;
    logic             w_error;

    assign w_fall     = r_clk_prev & ~bus.ps2_clk_i;
    assign w_accept   = bus.tx_valid && (r_state == S_IDLE);
    assign w_inh_last = (r_state == S_INHIBIT) && (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1));

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_wait_state;

    assign w_wait_state = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_timeout    = w_wait_state && (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

    // Counts from the first cycle with the clock released; held at the limit once reached.
    always_ff @(posedge clk) begin
        if (!resetn || !w_wait_state) begin
            r_to_cnt <= '0;
        end else if (!w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next  = r_state;
        w_done  = 1'b0;
        w_error = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_INHIBIT;
            end
            S_INHIBIT: begin
                if (w_inh_last) w_next = S_SEND;
            end
            S_SEND: begin
                if (w_timeout) begin
                    w_error = 1'b1;
                    w_next  = S_IDLE;
                end else if (w_fall && (r_bit_cnt == 4'd9)) begin
                    w_next = S_ACK;
                end
            end
            S_ACK: begin
                if (w_timeout) begin
                    w_error = 1'b1;
                    w_next  = S_IDLE;
                end else if (w_fall) begin
                    if (bus.ps2_data_i) begin
                        w_error = 1'b1;
                        w_next  = S_IDLE;
                    end else begin
                        w_next = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (w_timeout) begin
                    w_error = 1'b1;
                    w_next  = S_IDLE;
                end else if (bus.ps2_clk_i && bus.ps2_data_i) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_clk_prev <= 1'b0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_bit_cnt  <= '0;
            r_inh_cnt  <= '0;
            r_data_low <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_clk_prev <= bus.ps2_clk_i;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift    <= bus.tx_data;
                        r_parity   <= ~^bus.tx_data;
                        r_inh_cnt  <= '0;
                        r_bit_cnt  <= '0;
                        r_data_low <= 1'b0;
                    end
                end
                S_INHIBIT: begin
                    r_inh_cnt <= r_inh_cnt + 1'b1;
                    if (w_inh_last) r_data_low <= 1'b1;
                end
                S_SEND: begin
                    // Line update lands in the cycle after the fall; data bits leave LSB first.
                    if (w_fall && !w_timeout) begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt < 4'd8) begin
                            r_data_low <= ~r_shift[0];
                            r_shift    <= {1'b0, r_shift[7:1]};
                        end else if (r_bit_cnt == 4'd8) begin
                            r_data_low <= ~r_parity;
                        end else begin
                            r_data_low <= 1'b0;
                        end
                    end
                end
                S_ACK: begin
                    if (w_fall && (r_bit_cnt != 4'd11)) r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_ready     = (r_state == S_IDLE);
    assign bus.tx_busy      = (r_state != S_IDLE);
    assign bus.ps2_clk_low  = (r_state == S_INHIBIT);
    assign bus.ps2_data_low = w_inh_last || ((r_state == S_SEND) && r_data_low && !w_timeout);
    assign bus.tx_done      = resetn && w_done;
    assign bus.tx_error     = resetn && w_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND PS/2 device model clocking 40-cycle periods.
module tb_ps2_host_tx;

    logic clk;
    logic resetn;
    logic dev_clk_low;
    logic dev_data_low;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (20),
        .TIMEOUT_CYCLES (5000)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    assign bus.ps2_clk_i  = ~(bus.ps2_clk_low | dev_clk_low);
    assign bus.ps2_data_i = ~(bus.ps2_data_low | dev_data_low);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_pass;
    int cyc;
    int done_cnt, err_cnt, both_cnt, rdy_viol, clk_low_cnt;
    int done_cyc, err_cyc, inh_cyc;
    logic pulse_prev, clk_low_prev;

    initial begin
        cyc = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0; rdy_viol = 0; clk_low_cnt = 0;
        done_cyc = 0; err_cyc = 0; inh_cyc = 0; pulse_prev = 1'b0; clk_low_prev = 1'b0;
    end

    always @(posedge clk) cyc++;

    // Pulse/line bookkeeping sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.tx_done)  begin done_cnt++; done_cyc = cyc; end
        if (bus.tx_error) begin err_cnt++;  err_cyc  = cyc; end
        if (bus.tx_done && bus.tx_error) both_cnt++;
        if (pulse_prev && !bus.tx_ready) rdy_viol++;
        pulse_prev = bus.tx_done | bus.tx_error;
        if (bus.ps2_clk_low) clk_low_cnt++;
        if (bus.ps2_clk_low && !clk_low_prev) inh_cyc = cyc;
        clk_low_prev = bus.ps2_clk_low;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_accept(input string tag);
        logic rdy;
        int   n;
        n = 0;
        do begin
            rdy = bus.tx_ready;
            tick();
            n++;
        end while (!rdy && n < 2000);
        chk(tag, 32'(rdy), 32'd1);
    endtask

    // Device side: waits for request-to-send, reads start, clocks nclk periods, optional ACK.
    task automatic dev_xfer(input logic ack_low, input int nclk,
                            output logic [10:0] frame, output int rel_cyc);
        int n;
        frame   = '0;
        rel_cyc = 0;
        n = 0;
        while (!(bus.ps2_clk_low == 1'b0 && bus.ps2_data_low == 1'b1) && n < 300) begin
            tick();
            n++;
        end
        chk("rts_seen", 32'(n < 300), 32'd1);
        if (n >= 300) return;
        rel_cyc = cyc;
        repeat (5) tick();
        frame[0] = bus.ps2_data_i;
        for (int k = 1; k <= nclk; k++) begin
            dev_clk_low = 1'b1;
            repeat (20) tick();
            if (k <= 10) frame[k] = bus.ps2_data_i;
            dev_clk_low = 1'b0;
            repeat (10) tick();
            if (k == 10) dev_data_low = ack_low;
            repeat (10) tick();
        end
        dev_data_low = 1'b0;
        repeat (5) tick();
    endtask

    logic [10:0] fr;
    int          rel;
    int          d0, e0, c0, t;

    initial begin
        n_total = 0;
        n_pass  = 0;
        resetn = 1'b0;
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) tick();
        chk("rst_ready", 32'(bus.tx_ready), 32'd1);
        chk("rst_busy", 32'(bus.tx_busy), 32'd0);
        chk("rst_lines", {30'd0, bus.ps2_clk_low, bus.ps2_data_low}, 32'd0);
        chk("rst_pulses", {30'd0, bus.tx_done, bus.tx_error}, 32'd0);
        resetn = 1'b1;
        tick();

        // 1: reset in the middle of INHIBIT
        d0 = done_cnt; e0 = err_cnt;
        bus.tx_data = 8'h12; bus.tx_valid = 1'b1;
        wait_accept("t1_accept");
        bus.tx_valid = 1'b0;
        repeat (5) tick();
        chk("t1_inhibit", 32'(bus.ps2_clk_low), 32'd1);
        resetn = 1'b0;
        tick();
        chk("t1_lines", {30'd0, bus.ps2_clk_low, bus.ps2_data_low}, 32'd0);
        chk("t1_ready", 32'(bus.tx_ready), 32'd1);
        resetn = 1'b1;
        repeat (3) tick();
        chk("t1_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

        // 2: 0xED, ACK given
        d0 = done_cnt; e0 = err_cnt; c0 = clk_low_cnt;
        bus.tx_data = 8'hED; bus.tx_valid = 1'b1;
        wait_accept("t2_accept");
        bus.tx_valid = 1'b0;
        dev_xfer(1'b1, 11, fr, rel);
        repeat (3) tick();
        chk("t2_clk_low_cycles", 32'(clk_low_cnt - c0), 32'd20);
        chk("t2_frame", 32'(fr), 32'(11'b1_1_11101101_0));
        chk("t2_done", 32'(done_cnt - d0), 32'd1);
        chk("t2_error", 32'(err_cnt - e0), 32'd0);
        chk("t2_ready", 32'(bus.tx_ready), 32'd1);

        // 3: 0xFF then 0x01 with tx_valid held
        d0 = done_cnt; c0 = clk_low_cnt;
        bus.tx_data = 8'hFF; bus.tx_valid = 1'b1;
        wait_accept("t3_accept1");
        bus.tx_data = 8'h01;
        repeat (10) tick();
        chk("t3_ready_low", 32'(bus.tx_ready), 32'd0);
        dev_xfer(1'b1, 11, fr, rel);
        bus.tx_valid = 1'b0;
        chk("t3_frame1", 32'(fr), 32'(11'b1_1_11111111_0));
        chk("t3_gap", 32'(inh_cyc - done_cyc), 32'd2);
        dev_xfer(1'b1, 11, fr, rel);
        repeat (3) tick();
        chk("t3_frame2", 32'(fr), 32'(11'b1_0_00000001_0));
        chk("t3_done", 32'(done_cnt - d0), 32'd2);
        chk("t3_clk_low_cycles", 32'(clk_low_cnt - c0), 32'd40);

        // 4: ACK missing
        d0 = done_cnt; e0 = err_cnt;
        bus.tx_data = 8'h5A; bus.tx_valid = 1'b1;
        wait_accept("t4_accept");
        bus.tx_valid = 1'b0;
        dev_xfer(1'b0, 11, fr, rel);
        chk("t4_frame", 32'(fr), 32'(11'b1_1_01011010_0));
        chk("t4_error", 32'(err_cnt - e0), 32'd1);
        chk("t4_done", 32'(done_cnt - d0), 32'd0);
        chk("t4_ready", 32'(bus.tx_ready), 32'd1);
        chk("t4_lines", {30'd0, bus.ps2_clk_low, bus.ps2_data_low}, 32'd0);

        // 5: device stops clocking after 4 periods
        e0 = err_cnt;
        bus.tx_data = 8'hA5; bus.tx_valid = 1'b1;
        wait_accept("t5_accept");
        bus.tx_valid = 1'b0;
        dev_xfer(1'b0, 4, fr, rel);
`ifdef PS2_TX_TIMEOUT_EN
        t = 0;
        while (err_cnt == e0 && t < 6000) begin tick(); t++; end
        tick();
        chk("t5_error", 32'(err_cnt - e0), 32'd1);
        chk("t5_latency", 32'(err_cyc - rel), 32'd5000);
        chk("t5_lines", {30'd0, bus.ps2_clk_low, bus.ps2_data_low}, 32'd0);
        chk("t5_ready", 32'(bus.tx_ready), 32'd1);
`else
        t = 0;
        repeat (6000) tick();
        chk("t5_busy", 32'(bus.tx_busy), 32'd1);
        chk("t5_no_error", 32'(err_cnt - e0), 32'd0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        chk("t5_ready", 32'(bus.tx_ready), 32'd1);
`endif

        // 6: new request while SEND is in progress
        d0 = done_cnt;
        bus.tx_data = 8'h3C; bus.tx_valid = 1'b1;
        wait_accept("t6_accept");
        bus.tx_valid = 1'b0;
        fork
            dev_xfer(1'b1, 11, fr, rel);
            begin
                repeat (100) tick();
                bus.tx_data = 8'hC3; bus.tx_valid = 1'b1;
                repeat (40) tick();
                chk("t6_ready_low", 32'(bus.tx_ready), 32'd0);
                bus.tx_valid = 1'b0;
            end
        join
        repeat (3) tick();
        chk("t6_frame", 32'(fr), 32'(11'b1_1_00111100_0));
        chk("t6_done", 32'(done_cnt - d0), 32'd1);

        chk("pulse_overlap", 32'(both_cnt), 32'd0);
        chk("ready_after_pulse", 32'(rdy_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
